// File: rtl/tlb_params.sv
// Shared TLB types: search request/result, entry layout, and the arbiter FSM states.
package tlb_params;

  localparam int TLB_NUM = 16;
  localparam int IDX_W   = $clog2(TLB_NUM);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
  } search_request_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    logic [19:0]      pfn;
    logic             v;
    logic             d;
  } search_result_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn;
    logic        v;
    logic        d;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/tlb_access_arbiter.sv
// Arbitrates fetch and load/store searches onto one shared TLB search port and
// serialises TLB writes. Data wins by default; inst wins once it has lost
// STARVE_LIMIT times in a row. A write takes three cycles (accept, write,
// settle) during which no search is granted.
module tlb_access_arbiter
  import tlb_params::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int TLB_NUM      = tlb_params::TLB_NUM
) (
  input  logic                       clock,
  input  logic                       reset,

  input  logic                       inst_req_valid,
  input  search_request_t            inst_req,
  output logic                       inst_req_ready,
  output logic                       inst_resp_valid,
  output search_result_t             inst_resp,

  input  logic                       data_req_valid,
  input  search_request_t            data_req,
  output logic                       data_req_ready,
  output logic                       data_resp_valid,
  output search_result_t             data_resp,

  input  logic                       write_valid,
  input  logic [$clog2(TLB_NUM)-1:0] write_index,
  input  tlb_entry_t                 write_entry,
  output logic                       write_ready,
  output logic                       write_done,

  output search_request_t            tlb_search_req,
  input  search_result_t             tlb_search_result,

  output logic                       tlb_write_enable,
  output logic [$clog2(TLB_NUM)-1:0] tlb_write_index,
  output tlb_entry_t                 tlb_write_entry
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = $clog2(TLB_NUM);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  logic [SW-1:0]   starve_q;
  logic            search_ok;
  logic            inst_prio;
  logic            grant_inst;
  logic            grant_data;
  logic            inst_vld_q;
  logic            data_vld_q;
  logic [IW-1:0]   wr_idx_q;
  tlb_entry_t      wr_entry_q;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and write-side outputs; reset masks every strobe in the same cycle
  always_comb begin
    state_d          = state_q;
    write_ready      = 1'b0;
    tlb_write_enable = 1'b0;
    write_done       = 1'b0;
    search_ok        = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_valid) begin
          write_ready = 1'b1;
          state_d     = WRITE;
        end else begin
          search_ok = 1'b1;
        end
      end
      WRITE: begin
        tlb_write_enable = 1'b1;
        state_d          = SETTLE;
      end
      SETTLE: begin
        write_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      write_ready      = 1'b0;
      tlb_write_enable = 1'b0;
      write_done       = 1'b0;
      search_ok        = 1'b0;
    end
  end

  assign inst_prio      = (starve_q == STARVE_MAX) || !data_req_valid;
  assign grant_inst     = search_ok && inst_req_valid && inst_prio;
  assign grant_data     = search_ok && data_req_valid && !grant_inst;
  assign inst_req_ready = grant_inst;
  assign data_req_ready = grant_data;
  assign tlb_search_req = grant_data ? data_req : inst_req;

  // Starve counter: only real search cycles count, write cycles hold the value
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (search_ok) begin
      if (grant_inst || !inst_req_valid) starve_q <= '0;
      else if (starve_q != STARVE_MAX)   starve_q <= starve_q + SW'(1);
    end
  end

  // Capture the write so the TLB sees a stable index/entry in the WRITE cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idx_q   <= '0;
      wr_entry_q <= '0;
    end else if (write_ready) begin
      wr_idx_q   <= write_index;
      wr_entry_q <= write_entry;
    end
  end

  assign tlb_write_index = wr_idx_q;
  assign tlb_write_entry = wr_entry_q;

  // Register the search result for the granted port; data holds until the next grant
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      inst_resp  <= '0;
      data_resp  <= '0;
    end else begin
      inst_vld_q <= grant_inst;
      data_vld_q <= grant_data;
      if (grant_inst) inst_resp <= tlb_search_result;
      if (grant_data) data_resp <= tlb_search_result;
    end
  end

  // A reset arriving in the response cycle cancels the pulse
  assign inst_resp_valid = inst_vld_q && !reset;
  assign data_resp_valid = data_vld_q && !reset;

endmodule

// File: tb/tb_tlb_access_arbiter.sv
// Bench for tlb_access_arbiter: behavioural TLB memory, cycle-level reference
// model of the arbitration rules, directed table, corner sequences, random run.
module tb_tlb_access_arbiter;
  import tlb_params::*;

  localparam int LIM = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            inst_req_valid, inst_req_ready, inst_resp_valid;
  search_request_t inst_req;
  search_result_t  inst_resp;
  logic            data_req_valid, data_req_ready, data_resp_valid;
  search_request_t data_req;
  search_result_t  data_resp;
  logic            write_valid, write_ready, write_done;
  logic [IDX_W-1:0] write_index;
  tlb_entry_t      write_entry;
  search_request_t tlb_search_req;
  search_result_t  tlb_search_result;
  logic            tlb_write_enable;
  logic [IDX_W-1:0] tlb_write_index;
  tlb_entry_t      tlb_write_entry;

  always #5 clock = ~clock;

  tlb_access_arbiter #(.STARVE_LIMIT(LIM), .TLB_NUM(TLB_NUM)) dut (
    .clock(clock), .reset(reset),
    .inst_req_valid(inst_req_valid), .inst_req(inst_req), .inst_req_ready(inst_req_ready),
    .inst_resp_valid(inst_resp_valid), .inst_resp(inst_resp),
    .data_req_valid(data_req_valid), .data_req(data_req), .data_req_ready(data_req_ready),
    .data_resp_valid(data_resp_valid), .data_resp(data_resp),
    .write_valid(write_valid), .write_index(write_index), .write_entry(write_entry),
    .write_ready(write_ready), .write_done(write_done),
    .tlb_search_req(tlb_search_req), .tlb_search_result(tlb_search_result),
    .tlb_write_enable(tlb_write_enable), .tlb_write_index(tlb_write_index),
    .tlb_write_entry(tlb_write_entry)
  );

  // Behavioural TLB: lowest matching valid entry wins
  tlb_entry_t mem [TLB_NUM];
  logic       tb_clr;

  function automatic search_result_t lookup(input search_request_t q);
    search_result_t r;
    r = '0;
    for (int i = 0; i < TLB_NUM; i++) begin
      if (!r.found && mem[i].v && mem[i].vpn2 == q.vpn2 && (mem[i].g || mem[i].asid == q.asid)) begin
        r.found = 1'b1;
        r.index = IDX_W'(i);
        r.pfn   = mem[i].pfn;
        r.v     = 1'b1;
        r.d     = mem[i].d;
      end
    end
    return r;
  endfunction

  assign tlb_search_result = lookup(tlb_search_req);

  always @(posedge clock) begin
    if (tb_clr) begin
      for (int i = 0; i < TLB_NUM; i++) mem[i] <= '0;
    end else if (tlb_write_enable) begin
      mem[tlb_write_index] <= tlb_write_entry;
    end
  end

  // Reference model state: write phase (0 idle, 1 writing, 2 settling), loss count, pending responses
  int              phase, starve;
  bit              pend_i, pend_d;
  search_result_t  exp_ir, exp_dr;
  logic [IDX_W-1:0] cap_idx;
  tlb_entry_t      cap_e;

  int checks, errors;

  // Last sampled DUT outputs for directed checks
  logic s_ir, s_dr, s_wr, s_wen, s_done, s_irv, s_drv;
  search_result_t s_iresp, s_dresp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic search_request_t mkq(input logic [18:0] vpn, input logic [7:0] asid);
    search_request_t q;
    q.vpn2 = vpn;
    q.asid = asid;
    return q;
  endfunction

  function automatic tlb_entry_t mke(input logic [18:0] vpn, input logic [7:0] asid, input logic g,
                                     input logic [19:0] pfn, input logic v);
    tlb_entry_t e;
    e.vpn2 = vpn; e.asid = asid; e.g = g; e.pfn = pfn; e.v = v; e.d = 1'b1;
    return e;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance the model at posedge
  task automatic cycle(input bit iv, input search_request_t ir, input bit dv, input search_request_t dr,
                       input bit wv, input logic [IDX_W-1:0] wi, input tlb_entry_t we, input bit rst);
    bit e_wr, srch, gi, gd, e_wen, e_done;
    search_result_t lk;
    inst_req_valid = iv; inst_req = ir;
    data_req_valid = dv; data_req = dr;
    write_valid = wv; write_index = wi; write_entry = we;
    reset = rst;
    @(negedge clock);
    e_wr   = (phase == 0) && wv && !rst;
    srch   = (phase == 0) && !wv && !rst;
    gi     = srch && iv && (!dv || starve == LIM);
    gd     = srch && dv && !gi;
    e_wen  = (phase == 1) && !rst;
    e_done = (phase == 2) && !rst;
    lk     = gd ? lookup(dr) : lookup(ir);
    s_ir = inst_req_ready; s_dr = data_req_ready; s_wr = write_ready;
    s_wen = tlb_write_enable; s_done = write_done;
    s_irv = inst_resp_valid; s_drv = data_resp_valid;
    s_iresp = inst_resp; s_dresp = data_resp;
    chk("inst_req_ready", 64'(inst_req_ready), 64'(gi));
    chk("data_req_ready", 64'(data_req_ready), 64'(gd));
    chk("write_ready", 64'(write_ready), 64'(e_wr));
    chk("tlb_write_enable", 64'(tlb_write_enable), 64'(e_wen));
    chk("write_done", 64'(write_done), 64'(e_done));
    chk("inst_resp_valid", 64'(inst_resp_valid), 64'(pend_i && !rst));
    chk("data_resp_valid", 64'(data_resp_valid), 64'(pend_d && !rst));
    chk("inst_resp", 64'(inst_resp), 64'(exp_ir));
    chk("data_resp", 64'(data_resp), 64'(exp_dr));
    if (gi || gd) chk("tlb_search_req", 64'(tlb_search_req), 64'(gd ? dr : ir));
    if (e_wen) begin
      chk("tlb_write_index", 64'(tlb_write_index), 64'(cap_idx));
      chk("tlb_write_entry", 64'(tlb_write_entry), 64'(cap_e));
    end
    @(posedge clock);
    if (rst) begin
      phase = 0; starve = 0; pend_i = 0; pend_d = 0; exp_ir = '0; exp_dr = '0;
    end else begin
      if (e_wr) begin cap_idx = wi; cap_e = we; end
      case (phase)
        0: phase = e_wr ? 1 : 0;
        1: phase = 2;
        default: phase = 0;
      endcase
      if (srch) begin
        if (gi || !iv)        starve = 0;
        else if (starve < LIM) starve = starve + 1;
      end
      pend_i = gi; pend_d = gd;
      if (gi) exp_ir = lk;
      if (gd) exp_dr = lk;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_write(input logic [IDX_W-1:0] wi, input tlb_entry_t we);
    cycle(0, '0, 0, '0, 1, wi, we, 0);
    idle(2);
  endtask

  typedef struct packed {
    bit iv, dv, wv, e_ir, e_dr, e_wr, e_wen, e_done;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int run;
    bit rv;
    checks = 0; errors = 0;
    phase = 0; starve = 0; pend_i = 0; pend_d = 0;
    exp_ir = '0; exp_dr = '0; cap_idx = '0; cap_e = '0;
    tb_clr = 1'b1; reset = 1'b1;
    inst_req_valid = 0; inst_req = '0; data_req_valid = 0; data_req = '0;
    write_valid = 0; write_index = '0; write_entry = '0;
    @(posedge clock); #1;
    cycle(0, '0, 0, '0, 0, '0, '0, 1);
    cycle(1, mkq(19'h1, 8'h0), 1, mkq(19'h2, 8'h0), 1, 4'd3, '0, 1);
    tb_clr = 1'b0;
    idle(1);

    // Directed: starvation rotation, then a write preempting both ports
    //            iv dv wv ir dr wr wen done
    tbl[0]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].iv, mkq(19'h40 + 19'(i), 8'h1), tbl[i].dv, mkq(19'h80 + 19'(i), 8'h2),
            tbl[i].wv, 4'd7, mke(19'h00777, 8'h3, 1'b0, 20'h12345, 1'b1), 0);
      chk("tbl_inst_ready", 64'(s_ir), 64'(tbl[i].e_ir));
      chk("tbl_data_ready", 64'(s_dr), 64'(tbl[i].e_dr));
      chk("tbl_write_ready", 64'(s_wr), 64'(tbl[i].e_wr));
      chk("tbl_write_enable", 64'(s_wen), 64'(tbl[i].e_wen));
      chk("tbl_write_done", 64'(s_done), 64'(tbl[i].e_done));
    end
    idle(1);

    // Inst-only hit at index 5
    do_write(4'd5, mke(19'h00123, 8'h0, 1'b1, 20'hAAAAA, 1'b1));
    cycle(1, mkq(19'h00123, 8'h9), 0, '0, 0, '0, '0, 0);
    idle(1);
    chk("hit5_valid", 64'(s_irv), 64'd1);
    chk("hit5_found", 64'(s_iresp.found), 64'd1);
    chk("hit5_index", 64'(s_iresp.index), 64'd5);

    // Write then search the same vpn through the data port
    do_write(4'd2, mke(19'h00ABC, 8'h4, 1'b0, 20'h0BEEF, 1'b1));
    cycle(0, '0, 1, mkq(19'h00ABC, 8'h4), 0, '0, '0, 0);
    idle(1);
    chk("wr_search_valid", 64'(s_drv), 64'd1);
    chk("wr_search_found", 64'(s_dresp.found), 64'd1);
    chk("wr_search_index", 64'(s_dresp.index), 64'd2);

    // Reset in the WRITE cycle kills the enable; arbiter is back in IDLE
    cycle(0, '0, 0, '0, 1, 4'd9, mke(19'h00555, 8'h0, 1'b1, 20'h1, 1'b1), 0);
    cycle(0, '0, 0, '0, 0, '0, '0, 1);
    chk("rst_wr_enable", 64'(s_wen), 64'd0);
    cycle(0, '0, 0, '0, 0, '0, '0, 0);
    chk("rst_wr_after_en", 64'(s_wen), 64'd0);
    chk("rst_wr_after_done", 64'(s_done), 64'd0);
    cycle(0, '0, 1, mkq(19'h00555, 8'h0), 0, '0, '0, 0);
    chk("rst_wr_idle_grant", 64'(s_dr), 64'd1);
    idle(1);
    chk("rst_wr_not_written", 64'(s_dresp.found), 64'd0);

    // Reset in the response cycle drops the pulse
    cycle(1, mkq(19'h00123, 8'h0), 0, '0, 0, '0, '0, 0);
    cycle(0, '0, 0, '0, 0, '0, '0, 1);
    chk("rst_resp_drop", 64'(s_irv), 64'd0);
    idle(1);

    // Eight back-to-back data searches give eight unbroken responses
    run = 0;
    for (int k = 0; k < 9; k++) begin
      rv = (k < 8);
      cycle(0, '0, rv, mkq(19'(k), 8'h0), 0, '0, '0, 0);
      if (k > 0 && s_drv) run++;
    end
    idle(1);
    chk("b2b_resp_count", 64'(run), 64'd8);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 1) == 1, mkq(19'($urandom_range(0, 7)), 8'($urandom_range(0, 1))),
            $urandom_range(0, 1) == 1, mkq(19'($urandom_range(0, 7)), 8'($urandom_range(0, 1))),
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, TLB_NUM - 1)),
            mke(19'($urandom_range(0, 7)), 8'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                20'($urandom), 1'($urandom_range(0, 1))),
            $urandom_range(0, 49) == 0);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_access_arbiter.md
TLB_ACCESS_ARBITER -- requirements
Module: tlb_access_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive inst-port losses before inst gains priority.
REQ-002 SHALL have parameter TLB_NUM, default tlb_params::TLB_NUM: entry count, sizing index fields.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports inst_req_valid in 1, inst_req in search_request_t, inst_req_ready out 1: fetch search request channel.
REQ-006 SHALL have ports inst_resp_valid out 1, inst_resp out search_result_t: fetch search result.
REQ-007 SHALL have ports data_req_valid in 1, data_req in search_request_t, data_req_ready out 1: load/store search request channel.
REQ-008 SHALL have ports data_resp_valid out 1, data_resp out search_result_t: load/store search result.
REQ-009 SHALL have ports write_valid in 1, write_index in clog2(TLB_NUM), write_entry in tlb_entry_t, write_ready out 1, write_done out 1: TLB write channel (tlbwi/tlbwr).
REQ-010 SHALL have ports tlb_search_req out search_request_t, tlb_search_result in search_result_t: shared TLB search port; result combinational in the same cycle.
REQ-011 SHALL have ports tlb_write_enable out 1, tlb_write_index out clog2(TLB_NUM), tlb_write_entry out tlb_entry_t: TLB write port.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, SETTLE; searches are granted only in IDLE.
REQ-013 SHALL, in IDLE with write_valid=1, assert write_ready, grant no search that cycle, and go to WRITE.
REQ-014 SHALL, in WRITE, drive tlb_write_enable=1 for exactly one cycle with the captured index/entry, then go to SETTLE.
REQ-015 SHALL, in SETTLE, pulse write_done=1 for one cycle, grant no search, and return to IDLE.
REQ-016 SHALL, in IDLE without write_valid, grant at most one search per cycle: data over inst unless the starve counter equals STARVE_LIMIT, then inst.
REQ-017 SHALL assert req_ready only for the granted port in that cycle; a transfer is valid&&ready.
REQ-018 SHALL drive tlb_search_req from the granted request, and from inst_req when nothing is granted.
REQ-019 SHALL register tlb_search_result on grant and pulse the granted port's resp_valid exactly one cycle later (latency 1), holding resp data until the next response.
REQ-020 SHALL sustain one search per cycle back-to-back with no bubble while in IDLE.
REQ-021 SHALL increment the starve counter when inst_req_valid=1 and inst is not granted (saturating at STARVE_LIMIT), and clear it on an inst grant or when inst_req_valid=0.
REQ-022 SHALL let a write accepted in IDLE preempt pending searches; the cycles spent in WRITE/SETTLE do not count as inst losses.
REQ-023 SHALL apply no response back-pressure: requesters always accept a resp_valid pulse.
REQ-024 SHALL ignore write_valid outside IDLE; write_ready=0 in WRITE and SETTLE.

Reset
REQ-025 SHALL, on reset, enter IDLE, clear the starve counter, and drive every valid/ready/enable/done output and both resp registers to 0.
REQ-026 SHALL, on reset during WRITE, suppress tlb_write_enable in the following cycle.
REQ-027 SHALL, on reset in the cycle after a grant, drop the pending resp_valid pulse.

Structure
REQ-028 SHALL take search_request_t, search_result_t, tlb_entry_t and TLB_NUM from package tlb_params; the FSM state enum SHALL also be added to tlb_params.
REQ-029 SHALL be one flat module; no sub-module is required.

Verification
REQ-030 SHALL cover: inst only, vpn=19'h00123, TLB returns found=1 index=5 -> inst_resp_valid in cycle+1 with index=5.
REQ-031 SHALL cover: both ports valid in the same cycle -> data granted; inst granted on the 4th cycle (STARVE_LIMIT=3) while data remains valid.
REQ-032 SHALL cover: write_valid with index=7 while both ports are valid -> write_ready cycle 0, tlb_write_enable cycle 1, write_done cycle 2, first search grant cycle 3.
REQ-033 SHALL cover: write of vpn=19'h00ABC at index 2, then search for the same vpn -> found=1, index=2.
REQ-034 SHALL cover: reset asserted in the WRITE cycle -> tlb_write_enable=0 and state IDLE afterwards.
REQ-035 SHALL cover: 8 consecutive data requests -> 8 consecutive data_resp_valid pulses with no gap.
